sr_cmd_debouncer: RTL and testbench
===================================

# sr_cmd_debouncer

Input conditioning stage that sits directly upstream of the SR flip-flop. It takes two raw, asynchronous, bouncy push-button lines (set and reset) and synchronises and debounces each one. It then emits single-cycle `s`/`r` command pulses on debounced press. Simultaneous commands are resolved so the flip-flop never sees `s=1, r=1`.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive synchronised cycles an input must hold a new level before it is accepted; legal 2..255
- `CNT_W`, 8, debounce counter width; must hold `DEBOUNCE_CYCLES-1`
- `clk`  input  1  single clock; all flops rise-edge
- `rst`  input  1  asynchronous, active-low reset; asserting clears all state immediately
- `set_btn`  input  1  raw set request, asynchronous to `clk`
- `reset_btn`  input  1  raw reset request, asynchronous to `clk`
- `s`  output  1  registered one-cycle set command to the SR flip-flop
- `r`  output  1  registered one-cycle reset command to the SR flip-flop
- `conflict`  output  1  registered one-cycle flag: set and reset presses accepted on the same edge
- `set_level`  output  1  debounced level of `set_btn`
- `reset_level`  output  1  debounced level of `reset_btn`

## Operation
- Per channel: 2-flop synchroniser (`syncA`→`syncB`), debounce counter `cnt`, stable level `lvl`, 2-state FSM.
- FSM STABLE: `syncB == lvl`, `cnt` held at 0.
  - STABLE → PENDING when `syncB != lvl`; `cnt` increments to 1.
- FSM PENDING:
  - `syncB == lvl` (bounce back): `cnt` ← 0, → STABLE. No output.
  - `syncB != lvl` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
  - `syncB != lvl` and `cnt == DEBOUNCE_CYCLES-1`: `lvl` ← `syncB`, `cnt` ← 0, → STABLE.
- Press event: `lvl` transitions 0→1. Release (1→0) is debounced identically but generates no command.
- Command register, evaluated each edge from the press events of the previous cycle:
  - Only set press: `s`=1, `r`=0.
  - Only reset press: `r`=1, `s`=0.
  - Both press: `conflict`=1; `s`/`r` per Configuration.
  - Otherwise all three are 0.
- Invariant: `s` and `r` are never both 1.
- A held button yields exactly one pulse. A new pulse requires a debounced release followed by a debounced press.
- Reset values (while `rst`=0): `s`, `r`, `conflict`, `set_level`, `reset_level`, sync flops, counters all 0; FSMs in STABLE.
- Reset mid-operation: any pending count is discarded. A button held through reset release is treated as a fresh press.

## Timing
- Edge 0 is the first edge sampling raw high.
- `syncB`=1 after edge 1.
- `lvl`=1 after edge `DEBOUNCE_CYCLES+1`.
- `s` (or `r`) is high for exactly the cycle after edge `DEBOUNCE_CYCLES+2`. With default 4, `s` is high between edges 6 and 7.
- Any `syncB` run shorter than `DEBOUNCE_CYCLES` consecutive cycles is rejected.
- Outputs change only on rising `clk` or asserting `rst`. No combinational path from inputs to outputs.

## Configuration
- `SR_CMD_SET_PRIORITY_EN` defined: simultaneous press gives `s`=1, `r`=0, `conflict`=1.
- Not defined (default): simultaneous press gives `s`=0, `r`=0, `conflict`=1. Both commands are dropped.
- Either way, the `set_level`/`reset_level` paths are unaffected.

## Test plan
- Use `DEBOUNCE_CYCLES`=4 throughout.
- Clean press: `set_btn` 0→1 before edge 0, held for 20 cycles → `s`=1 only in the cycle after edge 6. `set_level`=1 after edge 5. `r` and `conflict` stay 0.
- Bounce: `set_btn` toggles 1,0,1,0 every cycle, then holds 1 → no `s` during toggling; exactly one `s` pulse 7 edges after the final stable 1.
- Glitch: `reset_btn` high for 3 cycles only → `r` and `reset_level` stay 0 throughout.
- Simultaneous press: both buttons rise before the same edge → after edge 6, `conflict`=1. Without the macro `s`=`r`=0; with the macro `s`=1, `r`=0.
- Reset mid-count: `set_btn` held high, `rst` pulsed low at edge 3, released at edge 4 → no pulse at edge 6; all outputs 0 during reset; `s` pulses once 7 edges after the first edge following reset release.
- Re-press: press set, release for 6 cycles, press again → two `s` pulses. A single hold of 30 cycles → one pulse.

Source files
------------

// File: rtl/sr_cmd_debouncer.sv
// Synchronise + debounce set/reset push-buttons and emit one-cycle s/r commands.
// Optional: define SR_CMD_SET_PRIORITY_EN so a simultaneous press yields s=1 instead of dropping both.

module sr_cmd_debouncer_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic press
);
    typedef enum logic {STABLE, PENDING} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic             sync_a, sync_b, lvl_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            lvl    <= 1'b0;
            lvl_d  <= 1'b0;
            cnt    <= '0;
            state  <= STABLE;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            lvl_d  <= lvl;
            case (state)
                STABLE: begin
                    if (sync_b != lvl) begin
                        cnt   <= CNT_W'(1);
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (sync_b == lvl) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (cnt == LAST) begin
                        lvl   <= sync_b;
                        cnt   <= '0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Rising edge of the debounced level; release edges are deliberately ignored.
    assign press = lvl & ~lvl_d;
endmodule

module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_level,
    output logic reset_level
);
    localparam int NUM_LANES = 2;
    localparam int SET_L     = 0;
    localparam int RST_L     = 1;

    logic [NUM_LANES-1:0] raw, lvl, press;

    assign raw = {reset_btn, set_btn};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            sr_cmd_debouncer_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw[g]),
                .lvl  (lvl[g]),
                .press(press[g])
            );
        end
    endgenerate

    assign set_level   = lvl[SET_L];
    assign reset_level = lvl[RST_L];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= press[SET_L] & press[RST_L];
            r        <= press[RST_L] & ~press[SET_L];
`ifdef SR_CMD_SET_PRIORITY_EN
            s        <= press[SET_L];
`else
            s        <= press[SET_L] & ~press[RST_L];
`endif
        end
    end
endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Scoreboard bench for sr_cmd_debouncer: expected pulses are queued when buttons are driven.
module tb_sr_cmd_debouncer;
    logic clk = 1'b0, rst = 1'b0, set_btn = 1'b0, reset_btn = 1'b0;
    logic s, r, conflict, set_level, reset_level;
    int   edge_n = 0, total = 0, bad = 0;
    int   k;
    logic seen;

    typedef struct {int at; logic [2:0] val;} exp_t;
    exp_t sb[$];

`ifdef SR_CMD_SET_PRIORITY_EN
    localparam logic [2:0] BOTH = 3'b101;
`else
    localparam logic [2:0] BOTH = 3'b001;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .s(s), .r(r), .conflict(conflict),
        .set_level(set_level), .reset_level(reset_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge the new level is driven: edge 0 is the next posedge,
    // the command is visible after edge 6, i.e. seven posedges from now.
    task automatic expect_pulse(input logic [2:0] v);
        exp_t e;
        e.at  = edge_n + 7;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && (s || r || conflict)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, s, r, conflict}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_edge", edge_n, e.at);
                chk("pulse_val", {29'd0, s, r, conflict}, {29'd0, e.val});
            end
        end
    end

    initial begin
        cyc(3);
        chk("rst_outs", {27'd0, s, r, conflict, set_level, reset_level}, 32'd0);
        rst = 1'b1;
        cyc(2);

        // clean set press held 20 cycles
        set_btn = 1'b1; expect_pulse(3'b100); k = edge_n;
        cyc(5); chk("clean_lvl_e4", {31'd0, set_level}, 32'd0);
        cyc(1); chk("clean_lvl_e5", {31'd0, set_level}, 32'd1);
        cyc(14); set_btn = 1'b0; cyc(12);
        chk("clean_drain", sb.size(), 0);

        // bounce then stable high
        set_btn = 1'b1; cyc(1); set_btn = 1'b0; cyc(1);
        set_btn = 1'b1; cyc(1); set_btn = 1'b0; cyc(1);
        set_btn = 1'b1; expect_pulse(3'b100);
        cyc(15); set_btn = 1'b0; cyc(12);
        chk("bounce_drain", sb.size(), 0);

        // 3-cycle glitch on reset_btn must be rejected
        seen = 1'b0; reset_btn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) reset_btn = 1'b0;
            cyc(1);
            seen = seen | reset_level;
        end
        chk("glitch_lvl", {31'd0, seen}, 32'd0);

        // clean reset press
        reset_btn = 1'b1; expect_pulse(3'b010);
        cyc(10); reset_btn = 1'b0; cyc(12);
        chk("rpress_drain", sb.size(), 0);

        // simultaneous press
        set_btn = 1'b1; reset_btn = 1'b1; expect_pulse(BOTH);
        cyc(6); chk("both_lvls", {30'd0, set_level, reset_level}, 32'd3);
        cyc(10); set_btn = 1'b0; reset_btn = 1'b0; cyc(12);
        chk("both_drain", sb.size(), 0);

        // reset asserted mid-count, button held through release
        set_btn = 1'b1; k = edge_n;
        cyc(3); rst = 1'b0; #1;
        chk("midrst_outs", {27'd0, s, r, conflict, set_level, reset_level}, 32'd0);
        cyc(1); rst = 1'b1; expect_pulse(3'b100);
        cyc(15); set_btn = 1'b0; cyc(12);
        chk("midrst_drain", sb.size(), 0);

        // re-press after a 6-cycle release, then one 30-cycle hold
        set_btn = 1'b1; expect_pulse(3'b100);
        cyc(10); set_btn = 1'b0; cyc(6);
        set_btn = 1'b1; expect_pulse(3'b100);
        cyc(30); set_btn = 1'b0; cyc(12);
        chk("repress_drain", sb.size(), 0);
        chk("final_lvls", {30'd0, set_level, reset_level}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
